// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: serialises {~cmd, cmd, ~addr, addr} (LSB first) or a repeat code.
// Drives an active-low envelope for receiver loopback and a carrier-gated LED output.
module ir_nec_tx #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int CARRIER_DIV = 1316,
  parameter int GAP_US      = 40000,
  parameter int LEAD_US     = 9000,
  parameter int SPACE_US    = 4500,
  parameter int RSPACE_US   = 2250,
  parameter int BIT_US      = 560,
  parameter int ONE_US      = 1690
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       start,
  input  logic       repeat_req,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
  output logic       busy,
  output logic       done,
  output logic       ir_env,
  output logic       ir_led
);

  localparam int TICK_DIV = CLK_HZ / 1_000_000;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CAR_LAST  = CW'(CARRIER_DIV - 1);
  localparam logic [CW-1:0] CAR_HIGH  = CW'(CARRIER_DIV / 3);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LEAD      = 3'd1,
    S_SPACE     = 3'd2,
    S_BIT_MARK  = 3'd3,
    S_BIT_SPACE = 3'd4,
    S_STOP      = 3'd5,
    S_GAP       = 3'd6
  } state_t;

  state_t        r_state, w_state;
  logic [TW-1:0] r_tick, w_tick;
  logic [15:0]   r_dur, w_dur;
  logic [CW-1:0] r_car, w_car;
  logic [5:0]    r_bit, w_bit;
  logic [31:0]   r_shift, w_shift;
  logic          r_rep, w_rep;
  logic          r_busy, r_done, r_env, r_led;
  logic          w_done, w_mark, w_tick_wrap, w_phase_end;
  logic [15:0]   w_len;

  // Phase length in microsecond ticks for the current state.
  function automatic logic [15:0] phase_len(input state_t s, input logic rep, input logic b);
    logic [15:0] len;
    case (s)
      S_LEAD:      len = 16'(LEAD_US);
      S_SPACE:     len = rep ? 16'(RSPACE_US) : 16'(SPACE_US);
      S_BIT_MARK:  len = 16'(BIT_US);
      S_BIT_SPACE: len = b ? 16'(ONE_US) : 16'(BIT_US);
      S_STOP:      len = 16'(BIT_US);
      S_GAP:       len = 16'(GAP_US);
      default:     len = 16'd1;
    endcase
    return len;
  endfunction

  assign w_len       = phase_len(r_state, r_rep, r_shift[0]);
  assign w_tick_wrap = (r_tick == TICK_LAST);
  assign w_phase_end = w_tick_wrap && (r_dur == (w_len - 16'd1));

  // Next-state and next-counter logic.
  always_comb begin
    w_state = r_state;
    w_tick  = w_tick_wrap ? {TW{1'b0}} : (r_tick + TW'(1));
    w_dur   = w_tick_wrap ? (r_dur + 16'd1) : r_dur;
    w_car   = (r_car == CAR_LAST) ? {CW{1'b0}} : (r_car + CW'(1));
    w_bit   = r_bit;
    w_shift = r_shift;
    w_rep   = r_rep;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tick = {TW{1'b0}};
        w_dur  = 16'd0;
        w_car  = {CW{1'b0}};
        if (start) begin
          w_state = S_LEAD;
          w_shift = {~cmd, cmd, ~addr, addr};
          w_bit   = 6'd0;
          w_rep   = 1'b0;
        end else if (repeat_req) begin
          w_state = S_LEAD;
          w_bit   = 6'd0;
          w_rep   = 1'b1;
        end else begin
          w_state = S_IDLE;
        end
      end
      default: begin
        if (w_phase_end) begin
          w_tick = {TW{1'b0}};
          w_dur  = 16'd0;
          w_car  = {CW{1'b0}};
          case (r_state)
            S_LEAD:     w_state = S_SPACE;
            S_SPACE:    w_state = r_rep ? S_STOP : S_BIT_MARK;
            S_BIT_MARK: w_state = S_BIT_SPACE;
            S_BIT_SPACE: begin
              w_shift = {1'b0, r_shift[31:1]};
              w_bit   = r_bit + 6'd1;
              w_state = (r_bit == 6'd31) ? S_STOP : S_BIT_MARK;
            end
            S_STOP:     w_state = S_GAP;
            S_GAP: begin
              w_state = S_IDLE;
              w_done  = 1'b1;
            end
            default:    w_state = S_IDLE;
          endcase
        end else begin
          w_state = r_state;
        end
      end
    endcase
    w_mark = (w_state == S_LEAD) || (w_state == S_BIT_MARK) || (w_state == S_STOP);
  end

  // State, counters and registered outputs; outputs follow the state they belong to.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tick  <= {TW{1'b0}};
      r_dur   <= 16'd0;
      r_car   <= {CW{1'b0}};
      r_bit   <= 6'd0;
      r_shift <= 32'd0;
      r_rep   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_env   <= 1'b1;
      r_led   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_tick  <= w_tick;
      r_dur   <= w_dur;
      r_car   <= w_car;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_rep   <= w_rep;
      r_busy  <= (w_state != S_IDLE);
      r_done  <= w_done;
      r_env   <= ~w_mark;
      r_led   <= w_mark && (w_car < CAR_HIGH);
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign ir_env = r_env;
  assign ir_led = r_led;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Scoreboard bench for ir_nec_tx: expected envelope segments are queued by the stimulus
// and a monitor measures each low/high run of ir_env (and the carrier) against them.
module tb_ir_nec_tx;

  localparam int CAR = 26, GAP = 400, LEAD = 900, SP = 450, RSP = 225, BIT = 56, ONE = 169;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, repeat_req = 1'b0;
  logic [7:0] addr = 8'h00, cmd = 8'h00;
  logic       busy, done, ir_env, ir_led;

  always #5 clk = ~clk;

  ir_nec_tx #(
    .CLK_HZ(1_000_000), .CARRIER_DIV(CAR), .GAP_US(GAP), .LEAD_US(LEAD),
    .SPACE_US(SP), .RSPACE_US(RSP), .BIT_US(BIT), .ONE_US(ONE)
  ) dut (
    .CLOCK_50(clk), .rst_n(rst_n), .start(start), .repeat_req(repeat_req),
    .addr(addr), .cmd(cmd), .busy(busy), .done(done), .ir_env(ir_env), .ir_led(ir_led)
  );

  typedef struct { int kind; int len; } seg_t;  // kind: 0 mark, 1 space, 2 gap ending in done
  seg_t exp_q[$];
  int   checks = 0, errors = 0, done_cnt = 0;
  int   cyc = 0, run_len = 0, pos = 0, led_err = 0, first_fall = 0, last_rise = 0;
  logic prev_env = 1'b1;

  task automatic push(input int k, input int l);
    seg_t s;
    s.kind = k;
    s.len  = l;
    exp_q.push_back(s);
  endtask

  task automatic push_frame(input logic [7:0] a, input logic [7:0] c);
    logic [31:0] w;
    w = {~c, c, ~a, a};
    push(0, LEAD);
    push(1, SP);
    for (int i = 0; i < 32; i++) begin
      push(0, BIT);
      push(1, w[i] ? ONE : BIT);
    end
    push(0, BIT);
    push(2, GAP);
  endtask

  task automatic push_repeat();
    push(0, LEAD);
    push(1, RSP);
    push(0, BIT);
    push(2, GAP);
  endtask

  task automatic pop_cmp(input int kind, input int len, input int lerr);
    seg_t s;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL seg_unexpected: got kind=%0d len=%0d, expected no segment", kind, len);
    end else begin
      s = exp_q.pop_front();
      if (s.kind != kind || s.len != len || lerr != 0) begin
        errors++;
        $display("FAIL seg: got kind=%0d len=%0d led_err=%0d, expected kind=%0d len=%0d led_err=0",
                 kind, len, lerr, s.kind, s.len);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: measures runs of ir_env while busy and the carrier pattern inside them.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        run_len  = 0;
        pos      = 0;
        led_err  = 0;
        prev_env = ir_env;
      end else begin
        if (ir_env != prev_env) begin
          if (run_len > 0) pop_cmp(prev_env ? 1 : 0, run_len, led_err);
          else if (!ir_env) first_fall = cyc;
          if (ir_env) last_rise = cyc;
          run_len = 0;
          pos     = 0;
          led_err = 0;
        end
        if (done) begin
          pop_cmp(2, run_len, led_err);
          run_len = 0;
          led_err = 0;
          done_cnt++;
        end
        if (busy) begin
          if (ir_led != ((!ir_env) && ((pos % CAR) < CAR / 3))) led_err++;
          run_len++;
          pos++;
        end
        prev_env = ir_env;
      end
    end
  end

  task automatic send(input logic s, input logic r, input logic [7:0] a, input logic [7:0] c);
    @(negedge clk);
    start = s; repeat_req = r; addr = a; cmd = c;
    @(negedge clk);
    start = 1'b0; repeat_req = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_env", ir_env, 0);
  endtask

  task automatic wait_done(input int budget);
    int n0, k;
    n0 = done_cnt;
    k  = 0;
    while (done_cnt == n0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk("done_arrived", done_cnt - n0, 1);
  endtask

  initial begin
    int n;
    // Reset held: outputs stay at reset values while start toggles
    repeat (3) begin
      @(negedge clk);
      start = ~start;
      @(negedge clk);
      chk("rst_env", ir_env, 1);
      chk("rst_led", ir_led, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", busy, 0);

    push_frame(8'h00, 8'h01);
    send(1'b1, 1'b0, 8'h00, 8'h01);
    wait_done(20000);
    chk("frame_span_01", last_rise - first_fall, 6798);

    // start and repeat together: the full frame wins
    push_frame(8'h00, 8'h02);
    send(1'b1, 1'b1, 8'h00, 8'h02);
    wait_done(20000);
    chk("frame_span_02", last_rise - first_fall, 6798);

    push_repeat();
    send(1'b0, 1'b1, 8'h00, 8'h00);
    wait_done(5000);
    chk("repeat_span", last_rise - first_fall, 1181);

    // Requests and input changes during LEAD are ignored
    push_frame(8'h00, 8'h03);
    send(1'b1, 1'b0, 8'h00, 8'h03);
    repeat (100) @(negedge clk);
    start = 1'b1; repeat_req = 1'b1; addr = 8'hFF; cmd = 8'h55;
    @(negedge clk);
    start = 1'b0; repeat_req = 1'b0;
    wait_done(20000);
    chk("frame_span_03", last_rise - first_fall, 6798);
    n = done_cnt;
    repeat (50) @(negedge clk);
    chk("no_queued_req", busy, 0);

    // Reset during bit 10 (bits 0..7 short, 8..9 long for addr 0x00)
    push_frame(8'h00, 8'h07);
    send(1'b1, 1'b0, 8'h00, 8'h07);
    repeat (2700) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_env", ir_env, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_led", ir_led, 0);
    chk("midrst_done", done, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (GAP + 200) @(negedge clk);
    chk("postrst_idle", busy, 0);
    chk("postrst_no_done", done_cnt - n, 0);

    push_frame(8'hA5, 8'h3C);
    send(1'b1, 1'b0, 8'hA5, 8'h3C);
    wait_done(20000);
    chk("frame_span_a5", last_rise - first_fall, 6798);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
